// File: rtl/imm_decode_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// imm_decode_ctrl_pkg
// Shared definitions for the decode-stage immediate controller:
//   - REG_LEN        : datapath / immediate width (only 32 is supported)
//   - imm_type_e     : select encoding for the shared immediate mux
//   - OPC_*          : RV32I major opcodes recognised by the classifier
//   - occ_state_e    : occupancy states of the 2-entry skid buffer
//   - entry_t        : one decoded buffer entry, plus its reset value
// ---------------------------------------------------------------------------
package imm_decode_ctrl_pkg;

    localparam int REG_LEN = 32;

    typedef enum logic [2:0] {
        IMM_J       = 3'b000,
        IMM_U       = 3'b001,
        IMM_B       = 3'b010,
        IMM_S       = 3'b011,
        IMM_I       = 3'b100,
        IMM_DEFAULT = 3'b101
    } imm_type_e;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_state_e;

    typedef struct packed {
        logic [REG_LEN-1:0] instr;
        imm_type_e          immType;
        logic               illegal;
        logic [REG_LEN-1:0] immJ;
        logic [REG_LEN-1:0] immU;
        logic [REG_LEN-1:0] immB;
        logic [REG_LEN-1:0] immS;
        logic [REG_LEN-1:0] immI;
    } entry_t;

    localparam entry_t ENTRY_RESET = '{
        instr:   '0,
        immType: IMM_DEFAULT,
        illegal: 1'b0,
        immJ:    '0,
        immU:    '0,
        immB:    '0,
        immS:    '0,
        immI:    '0
    };

endpackage

// File: rtl/imm_decode_ctrl_imm_gen.sv
// ---------------------------------------------------------------------------
// imm_gen
// Purely combinational opcode classifier and immediate extractor for one
// RV32I instruction word.
// Ports:
//   instr_i     in  32  raw instruction word
//   immType_o   out  3  immediate mux select derived from the opcode
//   immJ_o..immI_o out 32 sign-extended J/U/B/S/I candidate immediates
//   illegal_o   out  1  opcode not recognised
// ---------------------------------------------------------------------------
module imm_gen
    import imm_decode_ctrl_pkg::*;
(
    input  logic [REG_LEN-1:0] instr_i,
    output imm_type_e          immType_o,
    output logic [REG_LEN-1:0] immJ_o,
    output logic [REG_LEN-1:0] immU_o,
    output logic [REG_LEN-1:0] immB_o,
    output logic [REG_LEN-1:0] immS_o,
    output logic [REG_LEN-1:0] immI_o,
    output logic               illegal_o
);

    // Opcode classification; R-type (OP) is legal but carries no immediate,
    // so it shares the NONE select with unrecognised opcodes.
    always_comb begin
        immType_o = IMM_DEFAULT;
        illegal_o = 1'b0;
        case (instr_i[6:0])
            OPC_JAL:                       immType_o = IMM_J;
            OPC_LUI, OPC_AUIPC:            immType_o = IMM_U;
            OPC_BRANCH:                    immType_o = IMM_B;
            OPC_STORE:                     immType_o = IMM_S;
            OPC_OPIMM, OPC_LOAD, OPC_JALR,
            OPC_SYSTEM:                    immType_o = IMM_I;
            OPC_OP:                        immType_o = IMM_DEFAULT;
            default:                       illegal_o = 1'b1;
        endcase
    end

    // All candidates are always extracted; the mux select picks one later.
    assign immI_o = {{20{instr_i[31]}}, instr_i[31:20]};
    assign immS_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign immB_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                     instr_i[30:25], instr_i[11:8], 1'b0};
    assign immU_o = {instr_i[31:12], 12'b0};
    assign immJ_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                     instr_i[20], instr_i[30:21], 1'b0};

endmodule

// File: rtl/imm_decode_ctrl.sv
// ---------------------------------------------------------------------------
// imm_decode_ctrl
// Decode-stage controller: classifies each fetched RV32I instruction, extracts
// its candidate immediates and holds the decoded entry in a 2-entry skid
// buffer with valid/ready handshakes on both sides and a pipeline flush.
// Optional feature macro: IMM_STATS_EN (adds the illegal_cnt port).
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     fetch-side handshake, in_instr payload
//   flush                 synchronous pipeline flush
//   out_valid/out_ready   execute-side handshake
//   out_instr, out_imm_type, out_imm_J/U/B/S/I, out_illegal  head entry
//   illegal_cnt           saturating count of illegal pushes (IMM_STATS_EN)
// ---------------------------------------------------------------------------
module imm_decode_ctrl
    import imm_decode_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [REG_LEN-1:0] in_instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [REG_LEN-1:0] out_instr,
    output logic [2:0]         out_imm_type,
    output logic [REG_LEN-1:0] out_imm_J,
    output logic [REG_LEN-1:0] out_imm_U,
    output logic [REG_LEN-1:0] out_imm_B,
    output logic [REG_LEN-1:0] out_imm_S,
    output logic [REG_LEN-1:0] out_imm_I,
    output logic               out_illegal
`ifdef IMM_STATS_EN
    ,
    output logic [15:0]        illegal_cnt
`endif
);

    if (DEPTH != 2 || REG_LEN != 32) begin : g_badConfig
        $error("imm_decode_ctrl supports only DEPTH=2 and REG_LEN=32");
    end

    occ_state_e state_q, state_d;
    entry_t     mem_q [2];
    entry_t     newEntry;
    entry_t     headEntry;
    logic       wrPtr_q, rdPtr_q;
    logic       push, pop;

    imm_gen u_immGen (
        .instr_i   (in_instr),
        .immType_o (newEntry.immType),
        .immJ_o    (newEntry.immJ),
        .immU_o    (newEntry.immU),
        .immB_o    (newEntry.immB),
        .immS_o    (newEntry.immS),
        .immI_o    (newEntry.immI),
        .illegal_o (newEntry.illegal)
    );
    assign newEntry.instr = in_instr;

    // Handshake flags depend only on registered occupancy (rst just masks
    // in_ready so fetch sees no room while the buffer is being cleared).
    assign in_ready  = (state_q != ST_FULL) && !rst;
    assign out_valid = (state_q != ST_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_EMPTY;
        else     state_q <= state_d;
    end

    // Occupancy next-state; flush overrides any same-cycle push/pop.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (push) state_d = ST_ONE;
                ST_ONE: begin
                    if (push && !pop)      state_d = ST_FULL;
                    else if (pop && !push) state_d = ST_EMPTY;
                end
                ST_FULL:  if (pop) state_d = ST_ONE;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // Entry storage and 1-bit wrapping pointers. Clearing the storage on
    // rst/flush is what makes the idle outputs fall back to reset values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            mem_q[0] <= ENTRY_RESET;
            mem_q[1] <= ENTRY_RESET;
            wrPtr_q  <= 1'b0;
            rdPtr_q  <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wrPtr_q] <= newEntry;
                wrPtr_q        <= ~wrPtr_q;
            end
            if (pop) begin
                rdPtr_q <= ~rdPtr_q;
            end
        end
    end

    // When empty, the slot behind the read pointer is the entry that was
    // popped last, so showing it keeps the outputs holding their last value.
    assign headEntry = (state_q == ST_EMPTY) ? mem_q[~rdPtr_q] : mem_q[rdPtr_q];

    assign out_instr    = headEntry.instr;
    assign out_imm_type = headEntry.immType;
    assign out_imm_J    = headEntry.immJ;
    assign out_imm_U    = headEntry.immU;
    assign out_imm_B    = headEntry.immB;
    assign out_imm_S    = headEntry.immS;
    assign out_imm_I    = headEntry.immI;
    assign out_illegal  = headEntry.illegal;

`ifdef IMM_STATS_EN
    logic [15:0] illegalCnt_q;

    // Saturating illegal-push counter; survives flush, cleared only by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegalCnt_q <= '0;
        end else if (push && !flush && newEntry.illegal &&
                     illegalCnt_q != 16'hFFFF) begin
            illegalCnt_q <= illegalCnt_q + 16'd1;
        end
    end

    assign illegal_cnt = illegalCnt_q;
`endif

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_imm_decode_ctrl
// Scoreboard bench: the monitor keeps a queue of expected decoded entries
// built from a reference decoder, compares the DUT head against it every
// cycle and pops it on each accepted handshake.
// ---------------------------------------------------------------------------
module tb_imm_decode_ctrl;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  immType;
        logic        illegal;
        logic [31:0] j, u, b, s, i;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [2:0]  out_imm_type;
    logic [31:0] out_imm_J, out_imm_U, out_imm_B, out_imm_S, out_imm_I;
    logic        out_illegal;
`ifdef IMM_STATS_EN
    logic [15:0] illegal_cnt;
    int          modelCnt = 0;
`endif

    int   errors = 0;
    int   checks = 0;
    bit   started = 1'b0;
    exp_t expQ[$];
    exp_t lastShown;

    imm_decode_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_imm_type (out_imm_type),
        .out_imm_J    (out_imm_J),
        .out_imm_U    (out_imm_U),
        .out_imm_B    (out_imm_B),
        .out_imm_S    (out_imm_S),
        .out_imm_I    (out_imm_I),
        .out_illegal  (out_illegal)
`ifdef IMM_STATS_EN
        ,
        .illegal_cnt  (illegal_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Sign-extend an unsigned field value of the given width to 32 bits.
    function automatic logic [31:0] sext(longint val, int bits);
        longint r;
        r = val;
        if (val >= (longint'(1) << (bits - 1))) r = val - (longint'(1) << bits);
        return r[31:0];
    endfunction

    // Reference decoder: immediates assembled arithmetically from fields.
    function automatic exp_t refDecode(logic [31:0] w);
        exp_t   e;
        longint up;
        e.instr   = w;
        e.illegal = 1'b0;
        case (w[6:0])
            7'h6F:                      e.immType = 3'd0;
            7'h37, 7'h17:               e.immType = 3'd1;
            7'h63:                      e.immType = 3'd2;
            7'h23:                      e.immType = 3'd3;
            7'h13, 7'h03, 7'h67, 7'h73: e.immType = 3'd4;
            7'h33:                      e.immType = 3'd5;
            default: begin
                e.immType = 3'd5;
                e.illegal = 1'b1;
            end
        endcase
        e.i = sext(longint'(w[31:20]), 12);
        e.s = sext(longint'(w[31:25]) * 32 + longint'(w[11:7]), 12);
        e.b = sext(longint'(w[31]) * 4096 + longint'(w[7]) * 2048 +
                   longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2, 13);
        up  = longint'(w[31:12]) * 4096;
        e.u = up[31:0];
        e.j = sext(longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096 +
                   longint'(w[20]) * 2048 + longint'(w[30:21]) * 2, 21);
        return e;
    endfunction

    function automatic exp_t resetEntry();
        exp_t e;
        e.instr = '0; e.immType = 3'd5; e.illegal = 1'b0;
        e.j = '0; e.u = '0; e.b = '0; e.s = '0; e.i = '0;
        return e;
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare the presented head, then advance the model using the
    // inputs that the next rising edge will sample.
    always @(negedge clk) begin
        exp_t e;
        bit   acceptPush;
        if (started) begin
            checkOutput("in_ready", {31'b0, in_ready}, {31'b0, (!rst && expQ.size() < 2)});
            checkOutput("out_valid", {31'b0, out_valid}, {31'b0, (expQ.size() > 0)});
            e = (expQ.size() > 0) ? expQ[0] : lastShown;
            checkOutput("out_instr", out_instr, e.instr);
            checkOutput("out_imm_type", {29'b0, out_imm_type}, {29'b0, e.immType});
            checkOutput("out_illegal", {31'b0, out_illegal}, {31'b0, e.illegal});
            checkOutput("out_imm_J", out_imm_J, e.j);
            checkOutput("out_imm_U", out_imm_U, e.u);
            checkOutput("out_imm_B", out_imm_B, e.b);
            checkOutput("out_imm_S", out_imm_S, e.s);
            checkOutput("out_imm_I", out_imm_I, e.i);
`ifdef IMM_STATS_EN
            checkOutput("illegal_cnt", {16'b0, illegal_cnt}, modelCnt);
`endif
        end
        if (rst) begin
            expQ.delete();
            lastShown = resetEntry();
            started   = 1'b1;
`ifdef IMM_STATS_EN
            modelCnt = 0;
`endif
        end else if (flush) begin
            expQ.delete();
            lastShown = resetEntry();
        end else begin
            acceptPush = in_valid && (expQ.size() < 2);
            if (out_ready && expQ.size() > 0) lastShown = expQ.pop_front();
            if (acceptPush) begin
                e = refDecode(in_instr);
                expQ.push_back(e);
`ifdef IMM_STATS_EN
                if (e.illegal && modelCnt < 65535) modelCnt++;
`endif
            end
        end
    end

    task automatic applyStimulus(bit v, logic [31:0] w, bit rdy, bit fl);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_instr  = w;
        out_ready = rdy;
        flush     = fl;
    endtask

    logic [6:0] opcTable [11];

    initial begin
        logic [31:0] w;
        opcTable = '{7'h6F, 7'h37, 7'h17, 7'h63, 7'h23, 7'h13,
                     7'h03, 7'h67, 7'h73, 7'h33, 7'h7F};
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        applyStimulus(1, 32'h0080006F, 1, 0);
        applyStimulus(0, 32'h0, 1, 0);
        applyStimulus(0, 32'h0, 0, 0);

        applyStimulus(1, 32'hFFF00093, 0, 0);
        applyStimulus(1, 32'h123450B7, 0, 0);
        applyStimulus(0, 32'h0, 0, 0);
        applyStimulus(0, 32'h0, 0, 0);
        applyStimulus(0, 32'h0, 1, 0);
        applyStimulus(0, 32'h0, 1, 0);
        applyStimulus(0, 32'h0, 0, 0);

        applyStimulus(1, 32'hFE000EE3, 1, 0);
        applyStimulus(1, 32'h0020A223, 1, 0);
        applyStimulus(0, 32'h0, 1, 0);
        applyStimulus(0, 32'h0, 1, 0);

        applyStimulus(1, 32'h00100013, 0, 0);
        applyStimulus(1, 32'h00200013, 0, 0);
        applyStimulus(1, 32'h00300013, 1, 1);
        applyStimulus(0, 32'h0, 0, 0);
        applyStimulus(0, 32'h0, 0, 0);

        applyStimulus(1, 32'h00000037, 0, 0);
        for (int k = 1; k <= 8; k++) applyStimulus(1, 32'h00000037 | (k << 12), 1, 0);
        applyStimulus(0, 32'h0, 1, 0);
        applyStimulus(0, 32'h0, 1, 0);

        repeat (3) applyStimulus(1, 32'hFFFFFFFF, 1, 0);
        applyStimulus(0, 32'h0, 0, 1);
        applyStimulus(0, 32'h0, 0, 0);
        rst = 1'b1;
        applyStimulus(0, 32'h0, 0, 0);
        rst = 1'b0;
        applyStimulus(0, 32'h0, 0, 0);

        for (int k = 0; k < 400; k++) begin
            w = $urandom();
            w[6:0] = (k % 7 == 3) ? 7'($urandom()) : opcTable[$urandom_range(0, 10)];
            applyStimulus(($urandom_range(0, 3) != 0), w, ($urandom_range(0, 2) != 0),
                          ($urandom_range(0, 19) == 0));
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                applyStimulus(0, 32'h0, 0, 0);
                rst = 1'b0;
            end
        end
        applyStimulus(0, 32'h0, 1, 0);
        applyStimulus(0, 32'h0, 1, 0);
        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
